seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digit positions.
- Holds a tear-free double-buffered digit word and walks the digits in a fixed refresh schedule.
- Per digit slot it drives the decoder's BCD inputs and enable, plus a one-hot digit select.
- Inserts an anti-ghosting blank guard before every slot; supports leading-zero blanking and suppresses invalid BCD codes.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be 2 or more.
- PRESCALE, 1000, clock cycles per digit slot, guard included; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 2, guard cycles at the start of each slot with digit and decoder off; 0 removes the GUARD state.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- disp_en  in  1  scan enable; 0 blanks the display and holds the scanner idle.
- lz_blank  in  1  1 enables leading-zero blanking.
- wr_valid  in  1  new display word offered.
- wr_ready  out  1  pending buffer empty; write accepted when wr_valid and wr_ready are both 1.
- wr_data  in  4*NUM_DIGITS  BCD word; digit 0 (least significant) is wr_data[3:0].
- bcd_out  out  4  BCD code to the shared decoder.
- dec_en  out  1  decoder enable.
- digit_an  out  NUM_DIGITS  one-hot digit select, 1 = digit lit.
- scan_idx  out  clog2(NUM_DIGITS)  digit index currently scheduled.
- frame_done  out  1  one-cycle pulse after the last digit's slot ends.

Behaviour:
- Reset (rst_n=0 at a clk edge): bcd_out=0, dec_en=0, digit_an=0, scan_idx=0, frame_done=0, active buffer=0, pending empty, wr_ready=1, state IDLE.
- Reset mid-operation overrides everything and discards any pending word.
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Write handshake:
  - An accepted write stores wr_data in the pending buffer; wr_ready drops to 0 on the next cycle.
  - A write while wr_ready=0 is ignored; the offer holds off.
- Pending transfer: active <= pending and wr_ready returns to 1 only at a frame boundary, meaning an IDLE-to-scan start or the wrap from the last digit to digit 0.
  - The transfer uses pending as registered before the boundary cycle.
  - A write accepted in the boundary cycle itself lands in pending and is applied at the next boundary.
- States: IDLE, GUARD, SHOW.
  - IDLE: all outputs 0.
  - IDLE -> GUARD when disp_en=1 (SHOW if BLANK_CYCLES=0); scan_idx=0 and pending is transferred.
  - GUARD: lasts BLANK_CYCLES cycles. digit_an=0, dec_en=0, bcd_out = active digit[scan_idx] so the decoder settles.
  - SHOW: lasts PRESCALE-BLANK_CYCLES cycles. digit_an = one-hot(scan_idx) and dec_en=1, unless the slot is suppressed.
  - Suppressed slot: digit_an=0, dec_en=0, bcd_out still driven.
  - End of SHOW: scan_idx increments and the next slot starts in GUARD.
  - After the last digit: scan_idx wraps to 0, frame_done=1 for exactly that one cycle, and pending is transferred.
- Suppression rules:
  - Invalid code: the digit value is greater than 9.
  - Leading zero (lz_blank=1): digit i with i>0 is suppressed if it and all higher digits are 0. Digit 0 is never leading-zero blanked.
  - lz_blank is sampled every cycle and is not buffered.
- disp_en=0 in any state:
  - Next cycle goes to IDLE with all outputs 0 and scan_idx=0.
  - The slot counter is cleared; active and pending are preserved.
  - Re-enable restarts at digit 0, GUARD.
- A single internal counter counts 0..PRESCALE-1 per slot; no other timing state.

Test Plan (PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=4):
- Reset: rst_n=0 for 3 cycles with disp_en=1 and wr_valid=1 -> all outputs 0, wr_ready=1, nothing captured.
- Basic scan: write 0x1234, then disp_en=1.
  - Per slot: 2 cycles with digit_an=0000, then 6 cycles lit.
  - Lit sequence: digit_an 0001/0010/0100/1000 with bcd_out 4/3/2/1.
  - frame_done pulses once, 32 cycles after scan start.
- Tear-free update: write 0x5678 during slot 1.
  - wr_ready=0 from the next cycle; the rest of the frame still shows 1,2.
  - The next frame shows 8,7,6,5; wr_ready=1 at the boundary.
- Leading-zero blanking: 0x0070 with lz_blank=1 -> slots 3 and 2 have digit_an=0 and dec_en=0; slot 1 shows 7; slot 0 shows 0. With lz_blank=0, all four slots light.
- Invalid code: 0x00A5 with lz_blank=0 -> slot 1 has digit_an=0 and dec_en=0; slots 0, 2, 3 show 5, 0, 0.
- Enable drop: disp_en=0 in the middle of slot 2 -> outputs 0 next cycle. Re-enable restarts at scan_idx=0 in GUARD and shows the same active word.

Source files
------------

// File: rtl/seg_scan_controller_if.sv
// Write-side handshake bundle for seg_scan_controller.
// Ports: wr_valid/wr_data from the producer, wr_ready back from the scanner.
interface seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [4*NUM_DIGITS-1:0]   wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-seg scanner: one shared BCD decoder, NUM_DIGITS anodes,
// double-buffered word, blank guard per slot, LZ blanking, bad-BCD mask.
// Ports: i_clk, i_rst_n (sync, low), i_disp_en, i_lz_blank, wr (slave),
//        o_bcd_out, o_dec_en, o_digit_an, o_scan_idx, o_frame_done.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_disp_en,
  input  logic                          i_lz_blank,
  seg_scan_controller_if.slave          wr,
  output logic [3:0]                    o_bcd_out,
  output logic                          o_dec_en,
  output logic [NUM_DIGITS-1:0]         o_digit_an,
  output logic [$clog2(NUM_DIGITS)-1:0] o_scan_idx,
  output logic                          o_frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(PRESCALE + 1);

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHOW
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nxt_cnt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_nxt_idx;
  logic [DW-1:0]   r_active;
  logic [DW-1:0]   r_pend;
  logic [DW-1:0]   w_nxt_active;
  logic            r_full;

  logic            w_slot_end;
  logic            w_last;
  logic            w_wrap;
  logic            w_boundary;
  logic            w_accept;
  logic            w_hi_zero;
  logic            w_suppress;
  logic            w_lit;
  logic [3:0]      w_digit;

  assign wr.wr_ready = ~r_full;

  always_comb begin
    w_slot_end = (r_state != IDLE) &&
                 (r_cnt == CW'(PRESCALE - 1));
    w_last     = (r_idx == IW'(NUM_DIGITS - 1));
    w_wrap     = i_disp_en && w_slot_end && w_last;
    w_boundary = i_disp_en &&
                 ((r_state == IDLE) || (w_slot_end && w_last));
    w_accept   = wr.wr_valid && !r_full;

    // Swap uses the pending word as it stood before this edge.
    w_nxt_active = (w_boundary && r_full) ? r_pend : r_active;

    w_nxt_state = IDLE;
    w_nxt_cnt   = '0;
    w_nxt_idx   = '0;
    if (i_disp_en) begin
      if (r_state == IDLE || w_slot_end) begin
        w_nxt_cnt = '0;
        if (r_state == IDLE || w_last)
          w_nxt_idx = '0;
        else
          w_nxt_idx = r_idx + IW'(1);
      end else begin
        w_nxt_cnt = r_cnt + CW'(1);
        w_nxt_idx = r_idx;
      end
      w_nxt_state = (int'(w_nxt_cnt) < BLANK_CYCLES) ? GUARD : SHOW;
    end

    w_digit = w_nxt_active[{w_nxt_idx, 2'b00} +: 4];

    // Digit is a leading zero when it and every higher digit are 0.
    w_hi_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(w_nxt_idx) && w_nxt_active[4*j +: 4] != 4'd0)
        w_hi_zero = 1'b0;
    end

    w_suppress = (w_digit > 4'd9) ||
                 (i_lz_blank && (w_nxt_idx != '0) && w_hi_zero);
    w_lit      = (w_nxt_state == SHOW) && !w_suppress;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pend       <= '0;
      r_full       <= 1'b0;
      o_bcd_out    <= '0;
      o_dec_en     <= 1'b0;
      o_digit_an   <= '0;
      o_scan_idx   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_idx    <= w_nxt_idx;
      r_active <= w_nxt_active;

      if (w_boundary && r_full) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_pend <= wr.wr_data;
        r_full <= 1'b1;
      end

      // Decoder input keeps settling during the guard.
      o_bcd_out    <= (w_nxt_state == IDLE) ? 4'd0 : w_digit;
      o_dec_en     <= w_lit;
      o_digit_an   <= w_lit ? (NUM_DIGITS'(1) << w_nxt_idx) : '0;
      o_scan_idx   <= w_nxt_idx;
      o_frame_done <= w_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: directed pins plus
// randomized traffic against a time-based behavioural model.
module tb_seg_scan_controller;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         disp_en = 1'b0;
  logic         lz_blank = 1'b0;
  logic [3:0]   bcd;
  logic         dec_en;
  logic [N-1:0] an;
  logic [1:0]   sidx;
  logic         fd;

  seg_scan_controller_if #(.NUM_DIGITS(N)) wr ();

  seg_scan_controller #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_disp_en   (disp_en),
    .i_lz_blank  (lz_blank),
    .wr          (wr),
    .o_bcd_out   (bcd),
    .o_dec_en    (dec_en),
    .o_digit_an  (an),
    .o_scan_idx  (sidx),
    .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: scan time since start, not a state machine.
  bit          m_live = 0;
  bit          m_en = 0;
  int          m_t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  bit          m_full = 0;
  bit          m_fd = 0;
  bit          m_lz = 0;

  task automatic check_model();
    int d;
    int s;
    logic [3:0] eb;
    logic [N-1:0] ean;
    bit sup;
    bit lit;
    logic [12:0] got;
    logic [12:0] exp;
    eb = 0; ean = 0; lit = 0; d = 0;
    if (m_en) begin
      s   = m_t % P;
      d   = (m_t / P) % N;
      eb  = m_act[4*d +: 4];
      sup = (eb > 4'd9) ||
            (m_lz && d > 0 && ((m_act >> (4*d)) == 16'd0));
      lit = (s >= B) && !sup;
      ean = lit ? N'(1 << d) : '0;
    end
    exp = {eb, lit, ean, 2'(d), m_en ? m_fd : 1'b0, !m_full};
    got = {bcd, dec_en, an, sidx, fd, wr.wr_ready};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t: got bcd=%h en=%b an=%b idx=%0d fd=%b rdy=%b exp bcd=%h en=%b an=%b idx=%0d fd=%b rdy=%b",
               $time, bcd, dec_en, an, sidx, fd, wr.wr_ready,
               eb, lit, ean, d, m_en ? m_fd : 1'b0, !m_full);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    bit bnd;
    if (!rst_n) begin
      m_live = 1; m_en = 0; m_t = 0;
      m_act = '0; m_pend = '0; m_full = 0; m_fd = 0;
    end else begin
      acc  = wr.wr_valid && !m_full;
      bnd  = 0;
      m_fd = 0;
      if (!disp_en) begin
        m_en = 0; m_t = 0;
      end else if (!m_en) begin
        m_en = 1; m_t = 0; bnd = 1;
      end else begin
        m_t++;
        m_fd = (m_t % (P*N)) == 0;
        bnd  = m_fd;
      end
      if (bnd && m_full) begin
        m_act = m_pend; m_full = 0;
      end else if (acc) begin
        m_pend = wr.wr_data; m_full = 1;
      end
    end
    m_lz = lz_blank;
    #1;
    if (m_live) check_model();
  end

  task automatic pin(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", nm, got, exp);
    end
  endtask

  int c;

  task automatic go(int n);
    while (c < n) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic restart();
    disp_en = 1'b1;
    c = -1;
  endtask

  initial begin
    wr.wr_valid = 1'b1;
    wr.wr_data  = 16'hFFFF;
    rst_n = 1'b0; disp_en = 1'b1;
    repeat (3) @(negedge clk);
    pin("rst_wr_ready", wr.wr_ready, 1);
    pin("rst_an", an, 0);
    pin("rst_bcd", bcd, 0);
    rst_n = 1'b1; disp_en = 1'b0; wr.wr_valid = 1'b0;
    @(negedge clk);
    pin("rst_nothing_captured", wr.wr_ready, 1);
    pin("idle_dec_en", dec_en, 0);

    // basic scan + tear-free update
    wr.wr_valid = 1'b1; wr.wr_data = 16'h1234;
    @(negedge clk);
    wr.wr_valid = 1'b0;
    pin("wr_ready_drop", wr.wr_ready, 0);
    restart();
    go(0);
    pin("g0_an", an, 0); pin("g0_bcd", bcd, 4);
    pin("g0_rdy", wr.wr_ready, 1);
    go(2);  pin("s0_an", an, 1); pin("s0_bcd", bcd, 4);
    go(10); pin("s1_an", an, 2); pin("s1_bcd", bcd, 3);
    wr.wr_valid = 1'b1; wr.wr_data = 16'h5678;
    go(11); wr.wr_valid = 1'b0;
    pin("upd_rdy_low", wr.wr_ready, 0);
    go(18); pin("s2_an", an, 4); pin("s2_bcd", bcd, 2);
    go(26); pin("s3_an", an, 8); pin("s3_bcd", bcd, 1);
    go(31); pin("fd_early", fd, 0);
    go(32); pin("fd_pulse", fd, 1); pin("fd_rdy", wr.wr_ready, 1);
    pin("fd_bcd", bcd, 8);
    go(33); pin("fd_end", fd, 0);
    go(34); pin("f2s0_an", an, 1); pin("f2s0_bcd", bcd, 8);
    go(42); pin("f2s1_bcd", bcd, 7);

    // leading-zero blanking
    go(44);
    disp_en = 1'b0; lz_blank = 1'b1;
    wr.wr_valid = 1'b1; wr.wr_data = 16'h0070;
    @(negedge clk);
    wr.wr_valid = 1'b0;
    pin("lz_idle_an", an, 0);
    restart();
    go(2);  pin("lz_s0_an", an, 1); pin("lz_s0_bcd", bcd, 0);
    go(10); pin("lz_s1_an", an, 2); pin("lz_s1_bcd", bcd, 7);
    go(18); pin("lz_s2_an", an, 0); pin("lz_s2_en", dec_en, 0);
    go(26); pin("lz_s3_an", an, 0); pin("lz_s3_en", dec_en, 0);
    lz_blank = 1'b0;
    go(50); pin("nolz_s2_an", an, 4); pin("nolz_s2_en", dec_en, 1);
    go(58); pin("nolz_s3_an", an, 8);

    // invalid code + enable drop
    disp_en = 1'b0;
    wr.wr_valid = 1'b1; wr.wr_data = 16'h00A5;
    @(negedge clk);
    wr.wr_valid = 1'b0;
    restart();
    go(2);  pin("bad_s0_bcd", bcd, 5); pin("bad_s0_an", an, 1);
    go(10); pin("bad_s1_an", an, 0); pin("bad_s1_en", dec_en, 0);
    pin("bad_s1_bcd", bcd, 10);
    go(18); pin("bad_s2_an", an, 4); pin("bad_s2_bcd", bcd, 0);
    go(20); disp_en = 1'b0;
    go(21); pin("drop_an", an, 0); pin("drop_idx", sidx, 0);
    pin("drop_bcd", bcd, 0);
    restart();
    go(0); pin("re_idx", sidx, 0); pin("re_an", an, 0);
    pin("re_bcd", bcd, 5);
    go(2); pin("re_s0_an", an, 1); pin("re_s0_bcd", bcd, 5);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 599) != 0);
      disp_en = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      wr.wr_valid = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < N; k++) begin
        logic [3:0] dg;
        dg = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) dg = 4'd0;
        wr.wr_data[4*k +: 4] = dg;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
